jtcop_pal_arb: RTL

Arbiter for a single-port 1k x 16 palette RAM. The RAM is shared between the colour mixer's per-pixel video reads and 68000-side CPU reads/writes.
- Video always wins on pxl_cen cycles.
- CPU accesses are slotted into the remaining clock cycles; completion is signalled with a cpu_ok handshake.
- The block sits between the CPU bus decoder and the palette RAM, and replaces the dual-port RAM in the colour mixer.

---
 rtl/jtcop_pal_arb_if.sv | 15 +
 rtl/jtcop_pal_arb.sv | 78 +++++++
 2 files changed

// File: rtl/jtcop_pal_arb_if.sv
// jtcop_pal_arb_if: CPU-side palette bus between the 68000 bus decoder and the palette arbiter.
interface jtcop_pal_arb_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          cpu_cs;
  logic          cpu_rnw;
  logic [AW:1]   cpu_addr;
  logic [DW-1:0] cpu_dout;
  logic [1:0]    dsn;
  logic [DW-1:0] cpu_din;
  logic          cpu_ok;
  modport master(output cpu_cs, cpu_rnw, cpu_addr, cpu_dout, dsn, input cpu_din, cpu_ok);
  modport slave(input cpu_cs, cpu_rnw, cpu_addr, cpu_dout, dsn, output cpu_din, cpu_ok);
endinterface

// File: rtl/jtcop_pal_arb.sv
// jtcop_pal_arb: single-port palette RAM arbiter; video reads own pxl_cen cycles, CPU uses the rest.
// Define JTCOP_PALBLANK_EN to let CPU writes issue only during horizontal or vertical blanking.
module jtcop_pal_arb #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pxl_cen_i,
  input  logic           lhbl_i,
  input  logic           lvbl_i,
  input  logic [AW-1:0]  vid_addr_i,
  output logic [DW-1:0]  vid_data_o,
  jtcop_pal_arb_if.slave cpu,
  output logic [AW-1:0]  ram_addr_o,
  output logic [DW-1:0]  ram_din_o,
  output logic [1:0]     ram_we_o,
  input  logic [DW-1:0]  ram_dout_i
);
  typedef enum logic [1:0] {IDLE, REQ, RDW, DONE} state_t;
  state_t        state_q, state_d;
  logic          rnw_q, vid_rd_q, ok_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q, vid_q, din_q;
  logic [1:0]    dsn_q;
  logic          rd_slot, wr_slot, issue;
  assign rd_slot = !pxl_cen_i;
`ifdef JTCOP_PALBLANK_EN
  assign wr_slot = rd_slot && (!lhbl_i || !lvbl_i);
`else
  logic unused_blank;
  assign unused_blank = lhbl_i & lvbl_i;
  assign wr_slot = rd_slot;
`endif
  // A dropped cs aborts the request before it ever touches the RAM
  assign issue       = state_q == REQ && cpu.cpu_cs && (rnw_q ? rd_slot : wr_slot);
  assign ram_addr_o  = pxl_cen_i ? vid_addr_i : addr_q;
  assign ram_din_o   = data_q;
  assign ram_we_o    = issue && !rnw_q ? ~dsn_q : 2'b00;
  assign vid_data_o  = vid_q;
  assign cpu.cpu_din = din_q;
  assign cpu.cpu_ok  = ok_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cpu.cpu_cs && !ok_q ? REQ : IDLE;
      REQ:     state_d = !cpu.cpu_cs ? IDLE : issue ? (rnw_q ? RDW : DONE) : REQ;
      RDW:     state_d = DONE;
      default: state_d = cpu.cpu_cs ? DONE : IDLE;
    endcase
  end
  // ram_dout in RDW belongs to the CPU address issued in REQ, even if video owns this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vid_rd_q <= 1'b0;
      ok_q     <= 1'b0;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      dsn_q    <= 2'b11;
      vid_q    <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      vid_rd_q <= pxl_cen_i;
      ok_q     <= state_d == DONE;
      if (vid_rd_q) vid_q <= ram_dout_i;
      if (state_q == RDW) din_q <= ram_dout_i;
      if (state_q == IDLE && state_d == REQ) begin
        rnw_q  <= cpu.cpu_rnw;
        addr_q <= cpu.cpu_addr;
        data_q <= cpu.cpu_dout;
        dsn_q  <= cpu.dsn;
      end
    end
  end
endmodule
